// File: rtl/fw_sched_pkg.sv
// Shared types and widths for the floydWarshall job scheduler.
package fw_sched_pkg;

    localparam int unsigned GRAPH_W = 64;
    localparam int unsigned JOBS_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        RESP
    } state_t;

    // Result record minus the run-cycle count, whose width is a top-level parameter.
    typedef struct packed {
        logic [GRAPH_W-1:0] graph;
        logic               timeout;
    } res_rec_t;

endpackage

// File: rtl/fw_job_fifo.sv
// DEPTH x 64-bit synchronous job FIFO; read data comes straight from the storage registers.
module fw_job_fifo
    import fw_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [GRAPH_W-1:0] push_data,
    input  logic               pop,
    output logic [GRAPH_W-1:0] pop_data,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [GRAPH_W-1:0] mem [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; push and pop in the same cycle are both honoured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fw_job_scheduler.sv
// Launches queued floydWarshall jobs one at a time and reports a result record per job.
module fw_job_scheduler
    import fw_sched_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CW      = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [GRAPH_W-1:0] job_graph,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [GRAPH_W-1:0] res_graph,
    output logic [CW-1:0]      res_cycles,
    output logic               res_timeout,
    output logic               fw_start,
    input  logic               fw_busy,
    output logic [GRAPH_W-1:0] fw_graph,
    input  logic               fw_done,
    output logic               fw_stall,
    output logic               idle,
    output logic [JOBS_W-1:0]  jobs_done
);

    state_t             state;
    logic [GRAPH_W-1:0] job_q;
    logic [CW-1:0]      run_cnt;
    logic [CW-1:0]      cnt_inc;
    logic               timeout_q;
    logic               timeout_hit;
    res_rec_t           res_q;
    logic [CW-1:0]      res_cycles_q;
    logic [JOBS_W-1:0]  jobs_done_q;
    logic               fw_start_q;
    logic               fw_stall_q;
    logic               res_valid_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [GRAPH_W-1:0] fifo_data;

    fw_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (job_valid),
        .push_data (job_graph),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop = (state == IDLE) && enable && !fifo_empty;

    // Run-cycle count including the current RUN cycle, saturating, and the timeout match on it.
    always_comb begin
        cnt_inc     = (run_cnt == '1) ? run_cnt : run_cnt + CW'(1);
        timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
    end

    // Job FSM with all handshake and result outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            job_q        <= '0;
            run_cnt      <= '0;
            timeout_q    <= 1'b0;
            res_q        <= '0;
            res_cycles_q <= '0;
            jobs_done_q  <= '0;
            fw_start_q   <= 1'b0;
            fw_stall_q   <= 1'b1;
            res_valid_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        job_q      <= fifo_data;
                        fw_start_q <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!fw_busy) begin
                        fw_start_q <= 1'b0;
                        fw_stall_q <= 1'b0;
                        run_cnt    <= '0;
                        timeout_q  <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    run_cnt   <= cnt_inc;
                    timeout_q <= timeout_q | timeout_hit;
                    if (fw_done) begin
                        res_q.graph   <= job_q;
                        res_q.timeout <= timeout_q | timeout_hit;
                        res_cycles_q  <= cnt_inc;
                        fw_stall_q    <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        jobs_done_q <= jobs_done_q + JOBS_W'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign job_ready   = !fifo_full;
    assign res_valid   = res_valid_q;
    assign res_graph   = res_q.graph;
    assign res_cycles  = res_cycles_q;
    assign res_timeout = res_q.timeout;
    assign fw_start    = fw_start_q;
    assign fw_graph    = job_q;
    assign fw_stall    = fw_stall_q;
    assign idle        = fifo_empty && (state == IDLE);
    assign jobs_done   = jobs_done_q;

endmodule
